// File: rtl/ps2_pkg.sv
// Shared PS/2 set-2 constants and receiver frame-state encoding.
package ps2_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT   = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BREAK = 8'hF0;

  localparam logic [7:0] KEY_W = 8'h1D;
  localparam logic [7:0] KEY_A = 8'h1C;
  localparam logic [7:0] KEY_S = 8'h1B;
  localparam logic [7:0] KEY_D = 8'h23;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

endpackage

// File: rtl/ps2_clk_filter.sv
// Synchronises the PS/2 pins, deglitches ps2_clk and emits a one-cycle strobe
// on each accepted falling edge of the filtered clock.
module ps2_clk_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic data_sync,
  output logic fall
);

  localparam logic [3:0] CNT_LAST = 4'(FILTER_LEN - 1);

  logic [1:0] clk_sync;
  logic [1:0] data_sq;
  logic       clk_filt;
  logic [3:0] cnt;

  assign data_sync = data_sq[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync <= 2'b11;
      data_sq  <= 2'b11;
      clk_filt <= 1'b1;
      cnt      <= '0;
      fall     <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      data_sq  <= {data_sq[0], ps2_data};
      fall     <= 1'b0;
      // cnt tracks how many consecutive samples disagree with the filtered level
      if (clk_sync[1] == clk_filt) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        clk_filt <= clk_sync[1];
        cnt      <= '0;
        fall     <= ~clk_sync[1];
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard frame receiver: deserialises frames, strips E0/F0 prefixes and
// strobes make/break events with the decoded scancode.
//
//   state  | meaning
//   IDLE   | waiting for a start bit (data=0 on a clock fall)
//   DATA   | shifting in 8 data bits, LSB first
//   PARITY | capturing the odd-parity bit
//   STOP   | checking stop bit and parity, then decode or report error
module ps2_key_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key,
  output logic       key_pressed,
  output logic       key_released,
  output logic       key_extended,
  output logic       frame_err
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  ps2_state_e    state, state_n;
  logic          data_sync;
  logic          fall;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          parity_bit;
  logic [TW-1:0] tcnt;
  logic          ext, brk;
  logic          abort;
  logic          byte_ok;

  ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .data_sync (data_sync),
    .fall      (fall)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    abort   = 1'b0;
    byte_ok = 1'b0;
    case (state)
      IDLE:   if (fall && !data_sync) state_n = DATA;
      DATA:   if (fall && bit_cnt == 3'd7) state_n = PARITY;
      PARITY: if (fall) state_n = STOP;
      STOP: begin
        if (fall) begin
          state_n = IDLE;
          if (data_sync && ((^shreg) ^ parity_bit)) byte_ok = 1'b1;
          else                                      abort   = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    // a fall in the same cycle keeps the frame alive
    if (state != IDLE && !fall && tcnt == T_LAST) begin
      state_n = IDLE;
      abort   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt      <= '0;
      shreg        <= '0;
      parity_bit   <= 1'b0;
      tcnt         <= '0;
      ext          <= 1'b0;
      brk          <= 1'b0;
      key          <= 8'h00;
      key_extended <= 1'b0;
      key_pressed  <= 1'b0;
      key_released <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      key_pressed  <= 1'b0;
      key_released <= 1'b0;
      frame_err    <= abort;

      if (fall || state == IDLE) tcnt <= '0;
      else                       tcnt <= tcnt + 1'b1;

      if (fall) begin
        case (state)
          IDLE:   bit_cnt <= '0;
          DATA: begin
            shreg   <= {data_sync, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          PARITY: parity_bit <= data_sync;
          default: ;
        endcase
      end

      if (abort) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (byte_ok) begin
        if (shreg == PS2_PREFIX_EXT) begin
          ext <= 1'b1;
        end else if (shreg == PS2_PREFIX_BREAK) begin
          brk <= 1'b1;
        end else begin
          key          <= shreg;
          key_extended <= ext;
          key_pressed  <= ~brk;
          key_released <= brk;
          ext          <= 1'b0;
          brk          <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Directed PS/2 frame stimulus with an event-queue model of the make/break/
// error decode, checked against the receiver every cycle.
module tb_ps2_key_receiver;

  localparam int FL   = 4;
  localparam int TO   = 400;
  localparam int HALF = 50;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] key;
  logic       key_pressed, key_released, key_extended, frame_err;

  always #5 clk = ~clk;

  ps2_key_receiver #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .key          (key),
    .key_pressed  (key_pressed),
    .key_released (key_released),
    .key_extended (key_extended),
    .frame_err    (frame_err)
  );

  // kind is one-hot {frame_err, key_released, key_pressed}
  typedef struct {
    logic [2:0] kind;
    logic [7:0] code;
    logic       ext;
  } ev_t;

  localparam logic [2:0] EV_PRS = 3'b001;
  localparam logic [2:0] EV_REL = 3'b010;
  localparam logic [2:0] EV_ERR = 3'b100;

  ev_t        exp_q[$];
  int         errors = 0;
  int         checks = 0;
  int         n_press = 0, n_rel = 0, n_err = 0;
  logic       m_ext = 1'b0, m_brk = 1'b0;
  logic [7:0] c_key = 8'h00;
  logic       c_ext = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural decode: prefixes only arm flags, any error drops them.
  task automatic model_frame(input logic [7:0] b, input bit ok);
    if (!ok) begin
      exp_q.push_back('{EV_ERR, 8'h00, 1'b0});
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      exp_q.push_back('{(m_brk ? EV_REL : EV_PRS), b, m_ext});
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic ps2_bit(input logic v, input bit glitch);
    @(negedge clk);
    ps2_data = v;
    if (glitch) begin
      repeat (20) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (FL - 1) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (HALF - 20 - (FL - 1)) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int glitch_bit);
    logic par;
    par = (~^b) ^ bad_par;
    ps2_bit(1'b0, glitch_bit == 0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], glitch_bit == i + 1);
    ps2_bit(par, 1'b0);
    @(negedge clk);
    ps2_data = ~bad_stop;
    repeat (HALF) @(negedge clk);
    model_frame(b, !bad_par && !bad_stop);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (100) @(negedge clk);
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (!rst) begin
      c_key = 8'h00;
      c_ext = 1'b0;
    end else begin
      if (key_pressed)  n_press++;
      if (key_released) n_rel++;
      if (frame_err)    n_err++;
      if (key_pressed || key_released || frame_err) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {29'd0, frame_err, key_released, key_pressed}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_kind", {29'd0, frame_err, key_released, key_pressed}, {29'd0, e.kind});
          if (e.kind != EV_ERR) begin
            c_key = e.code;
            c_ext = e.ext;
          end
        end
      end
      chk("key", key, c_key);
      chk("key_extended", key_extended, c_ext);
    end
  end

  initial begin
    repeat (4) @(negedge clk);
    chk("rst_key", key, 8'h00);
    chk("rst_ext", key_extended, 1'b0);
    chk("rst_pulses", {key_pressed, key_released, frame_err}, 3'b000);
    rst = 1'b1;
    repeat (20) @(negedge clk);

    // plain make 0x1D (parity bit 1)
    send_frame(8'h1D, 0, 0, -1);
    chk("make_1d_key", key, 8'h1D);
    chk("make_1d_ext", key_extended, 1'b0);
    chk("make_1d_press", n_press, 1);
    chk("make_1d_rel", n_rel, 0);

    // break F0 1C
    send_frame(8'hF0, 0, 0, -1);
    chk("after_f0_press", n_press, 1);
    chk("after_f0_rel", n_rel, 0);
    send_frame(8'h1C, 0, 0, -1);
    chk("break_1c_key", key, 8'h1C);
    chk("break_1c_rel", n_rel, 1);
    chk("break_1c_press", n_press, 1);

    // extended make E0 75, then plain 23
    send_frame(8'hE0, 0, 0, -1);
    send_frame(8'h75, 0, 0, -1);
    chk("ext_75_key", key, 8'h75);
    chk("ext_75_ext", key_extended, 1'b1);
    chk("ext_75_press", n_press, 2);
    send_frame(8'h23, 0, 0, -1);
    chk("plain_23_ext", key_extended, 1'b0);
    chk("plain_23_press", n_press, 3);

    // 0x23 has odd weight so the correct parity bit is 0; the bad frame sends 1
    send_frame(8'h1B, 0, 0, -1);
    send_frame(8'h23, 1, 0, -1);
    chk("badpar_err", n_err, 1);
    chk("badpar_key", key, 8'h1B);
    chk("badpar_press", n_press, 4);
    send_frame(8'h23, 0, 0, -1);
    chk("goodpar_key", key, 8'h23);
    send_frame(8'h1D, 0, 1, -1);
    chk("badstop_err", n_err, 2);
    chk("badstop_key", key, 8'h23);

    // break prefix, then partial frame that times out: flags must be dropped
    send_frame(8'hF0, 0, 0, -1);
    ps2_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1, 0);
    model_frame(8'h00, 0);
    repeat (TO + 10) @(negedge clk);
    chk("timeout_err", n_err, 3);
    send_frame(8'h1B, 0, 0, -1);
    chk("post_to_key", key, 8'h1B);
    chk("post_to_press", n_press, 6);
    chk("post_to_rel", n_rel, 1);

    // short ps2_clk glitch inside a frame
    send_frame(8'h1C, 0, 0, 3);
    chk("glitch_key", key, 8'h1C);
    chk("glitch_press", n_press, 7);
    chk("glitch_err", n_err, 3);

    // extended prefix, partial frame, then reset
    send_frame(8'hE0, 0, 0, -1);
    ps2_bit(1'b0, 0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b1, 0);
    @(negedge clk);
    rst = 1'b0;
    m_ext = 1'b0;
    m_brk = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_key", key, 8'h00);
    chk("midrst_pulses", {key_pressed, key_released, frame_err}, 3'b000);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(8'h1D, 0, 0, -1);
    chk("post_rst_key", key, 8'h1D);
    chk("post_rst_ext", key_extended, 1'b0);
    chk("post_rst_press", n_press, 8);

    chk("events_left", exp_q.size(), 0);
    chk("total_err", n_err, 3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
